df_addr_seq: RTL and testbench

DF_ADDR_SEQ -- requirements
Module: df_addr_seq

---
 rtl/df_addr_seq.sv | 144 ++++++++++++++
 tb/tb_df_addr_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/df_addr_seq.sv
// Multi-pass RAM address sequencer with stall, abort and a one-cycle done pulse.
// Optional macro DF_ADDR_SEQ_DOWN_EN adds a dir input for descending passes.
module df_addr_seq #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 8,
   parameter int PASS_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_rdy,
   input  logic              stall,
   input  logic [PASS_W-1:0] passes,
`ifdef DF_ADDR_SEQ_DOWN_EN
   input  logic              dir,
`endif
   output logic [ADDR_W-1:0] sel,
   output logic              sel_rdy,
   output logic              last,
   output logic              done
);

   localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONES = '1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] sel_q, sel_d;
   logic              rdy_q, rdy_d;
   logic [PASS_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;

   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] wrap_addr;
   logic [ADDR_W-1:0] final_addr;
   logic [ADDR_W-1:0] step_addr;

`ifdef DF_ADDR_SEQ_DOWN_EN
   logic dir_q, dir_d;

   // start_addr uses the live dir; everything later uses the sampled copy
   always_comb begin
      start_addr = dir ? TOP : '0;
      wrap_addr  = dir_q ? TOP : '0;
      final_addr = dir_q ? '0 : TOP;
      step_addr  = dir_q ? sel_q - 1'b1 : sel_q + 1'b1;
   end
`else
   always_comb begin
      start_addr = '0;
      wrap_addr  = '0;
      final_addr = TOP;
      step_addr  = sel_q + 1'b1;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= ONES;
         rdy_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef DF_ADDR_SEQ_DOWN_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rdy_q   <= rdy_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef DF_ADDR_SEQ_DOWN_EN
         dir_q   <= dir_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rdy_d   = rdy_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef DF_ADDR_SEQ_DOWN_EN
      dir_d   = dir_q;
`endif
      unique case (state_q)
         IDLE: begin
            sel_d = ONES;
            rdy_d = 1'b0;
            if (in_rdy) begin
               state_d = RUN;
               sel_d   = start_addr;
               rdy_d   = 1'b1;
               cnt_d   = passes;
`ifdef DF_ADDR_SEQ_DOWN_EN
               dir_d   = dir;
`endif
            end
         end
         RUN: begin
            // abort wins over stall; a stall-recovery cycle re-presents sel
            if (!in_rdy) begin
               state_d = IDLE;
               sel_d   = ONES;
               rdy_d   = 1'b0;
            end else if (stall) begin
               rdy_d = 1'b0;
            end else if (!rdy_q) begin
               rdy_d = 1'b1;
            end else if (sel_q != final_addr) begin
               sel_d = step_addr;
            end else if (cnt_q != '0) begin
               sel_d = wrap_addr;
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = DONE;
               sel_d   = ONES;
               rdy_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            sel_d = ONES;
            rdy_d = 1'b0;
            if (!in_rdy) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            sel_d   = ONES;
            rdy_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      sel     = sel_q;
      sel_rdy = rdy_q;
      last    = rdy_q && (sel_q == final_addr);
      done    = done_q;
   end

endmodule

// File: tb/tb_df_addr_seq.sv
// Randomised bench for df_addr_seq against a queue-of-addresses model.
// Define DF_ADDR_SEQ_DOWN_EN to also exercise descending passes.
module tb_df_addr_seq;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 8;
   localparam int PASS_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_rdy;
   logic              stall;
   logic [PASS_W-1:0] passes;
   logic [ADDR_W-1:0] sel;
   logic              sel_rdy;
   logic              last;
   logic              done;
`ifdef DF_ADDR_SEQ_DOWN_EN
   logic              dir;
`endif

   df_addr_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PASS_W(PASS_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .in_rdy  (in_rdy),
      .stall   (stall),
      .passes  (passes),
`ifdef DF_ADDR_SEQ_DOWN_EN
      .dir     (dir),
`endif
      .sel     (sel),
      .sel_rdy (sel_rdy),
      .last    (last),
      .done    (done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int dcount = 0;

   // model: remaining addresses of the whole sequence, front = current sel
   int q[$];
   bit m_run, m_rdy, m_wait, m_done;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_run  = 0;
      m_rdy  = 0;
      m_wait = 0;
      m_done = 0;
   endtask

   task automatic model_start();
      bit down = 0;
`ifdef DF_ADDR_SEQ_DOWN_EN
      down = dir;
`endif
      q.delete();
      for (int p = 0; p <= int'(passes); p++)
         for (int i = 0; i < DEPTH; i++)
            q.push_back(down ? DEPTH - 1 - i : i);
      m_run = 1;
      m_rdy = 1;
   endtask

   task automatic model_step();
      m_done = 0;
      if (m_wait) begin
         if (!in_rdy) m_wait = 0;
      end else if (!m_run) begin
         if (in_rdy) model_start();
      end else if (!in_rdy) begin
         q.delete();
         m_run = 0;
         m_rdy = 0;
      end else if (stall) begin
         m_rdy = 0;
      end else if (!m_rdy) begin
         m_rdy = 1;
      end else begin
         void'(q.pop_front());
         if (q.size() == 0) begin
            m_run  = 0;
            m_rdy  = 0;
            m_done = 1;
            m_wait = 1;
         end
      end
   endtask

   task automatic compare();
      int e_sel;
      bit e_last;
      e_sel  = m_run ? q[0] : 15;
      e_last = m_rdy && (q.size() % DEPTH == 1);
      chk("sel", 32'(sel), 32'(e_sel));
      chk("sel_rdy", 32'(sel_rdy), 32'(m_rdy));
      chk("last", 32'(last), 32'(e_last));
      chk("done", 32'(done), 32'(m_done));
      if (done) dcount++;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_sel(input int v);
      int k = 0;
      while (!(m_run && m_rdy && q[0] == v) && k < 60) begin
         cycle();
         k++;
      end
      if (k >= 60) chk("wait_sel_timeout", 32'(k), 32'(0));
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      #1 model_reset();
      compare();
      #1 reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      in_rdy = 1'b0;
      stall  = 1'b0;
      passes = '0;
`ifdef DF_ADDR_SEQ_DOWN_EN
      dir    = 1'b0;
`endif
      model_reset();
      #1 compare();
      run(2);
      reset = 1'b0;
      run(2);

      // single pass, no restart while in_rdy stays high
      dcount = 0;
      in_rdy = 1'b1;
      run(14);
      chk("one_pass_done_cnt", 32'(dcount), 32'(1));
      in_rdy = 1'b0;
      run(2);

      // three passes; passes changes mid-run must be ignored
      dcount = 0;
      passes = 4'd2;
      in_rdy = 1'b1;
      run(4);
      passes = 4'd9;
      run(26);
      chk("three_pass_done_cnt", 32'(dcount), 32'(1));
      in_rdy = 1'b0;
      run(2);

      // two-cycle stall at sel=3
      passes = 4'd0;
      in_rdy = 1'b1;
      wait_sel(3);
      stall = 1'b1;
      run(2);
      stall = 1'b0;
      run(10);
      in_rdy = 1'b0;
      run(2);

      // abort at sel=5, then restart from 0
      dcount = 0;
      in_rdy = 1'b1;
      wait_sel(5);
      in_rdy = 1'b0;
      run(1);
      in_rdy = 1'b1;
      run(3);
      chk("abort_no_done", 32'(dcount), 32'(0));

      // async reset at sel=6 between edges
      dcount = 0;
      wait_sel(6);
      async_reset();
      in_rdy = 1'b0;
      run(3);
      chk("reset_no_done", 32'(dcount), 32'(0));

`ifdef DF_ADDR_SEQ_DOWN_EN
      // descending, two passes
      dcount = 0;
      dir    = 1'b1;
      passes = 4'd1;
      in_rdy = 1'b1;
      run(20);
      chk("down_done_cnt", 32'(dcount), 32'(1));
      in_rdy = 1'b0;
      run(2);
`endif

      // random stress
      for (int i = 0; i < 3000; i++) begin
         in_rdy = ($urandom_range(0, 24) != 0);
         stall  = ($urandom_range(0, 3) == 0);
         passes = PASS_W'($urandom_range(0, 3));
`ifdef DF_ADDR_SEQ_DOWN_EN
         dir    = 1'($urandom_range(0, 1));
`endif
         if ($urandom_range(0, 299) == 0) async_reset();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
